key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL expose parameter CLK_FREQ_HZ, default 50_000_000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL expose parameter NUM_KEYS, default 4, meaning the number of independent pushbutton channels.
REQ-003 The block SHALL expose parameter DEBOUNCE_MS, default 10, meaning the required stable time in milliseconds before a level change is accepted.
REQ-004 The block SHALL expose parameter REPEAT_DELAY_MS, default 500, meaning the hold time before the first auto-repeat pulse (used only under KEY_REPEAT_EN).
REQ-005 The block SHALL expose parameter REPEAT_RATE_MS, default 100, meaning the auto-repeat pulse period (used only under KEY_REPEAT_EN).
REQ-006 clk  input  1  system clock; reset_n  input  1  reset, asynchronous, active-low.
REQ-007 key_n  input  NUM_KEYS  raw board KEY pins, active-low, asynchronous to clk.
REQ-008 key_level  output  NUM_KEYS  debounced level, 1 = held.
REQ-009 key_press  output  NUM_KEYS  one-cycle pulse per accepted press (and per repeat); drives screen_fsm enter.
REQ-010 key_release  output  NUM_KEYS  one-cycle pulse per accepted release.

Function
REQ-011 Each channel SHALL pass key_n[i] through a two-flop synchronizer, then invert it to give the active-high sample s[i]; no other logic touches the raw key_n.
REQ-012 DB_CYCLES SHALL be (CLK_FREQ_HZ/1000)*DEBOUNCE_MS, clamped to a minimum of 1; counter width SHALL be $clog2 of the largest cycle constant plus 1, so no wrap occurs.
REQ-013 Each channel SHALL run a four-state FSM: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-014 RELEASED: s=1 -> PRESS_WAIT with the counter cleared; otherwise stay.
REQ-015 PRESS_WAIT: s=0 -> RELEASED (bounce rejected, no pulse); counter reaching DB_CYCLES-1 with s=1 -> HELD; otherwise increment.
REQ-016 HELD: s=0 -> RELEASE_WAIT with the counter cleared; otherwise stay.
REQ-017 RELEASE_WAIT: s=1 -> HELD (no pulse); counter reaching DB_CYCLES-1 with s=0 -> RELEASED; otherwise increment.
REQ-018 key_level[i] SHALL be 1 exactly in HELD and RELEASE_WAIT.
REQ-019 key_press[i] SHALL be high for exactly the one cycle in which key_level[i] rises; key_release[i] SHALL be high for exactly the one cycle in which key_level[i] falls.
REQ-020 Latency: for a clean edge on key_n, key_level and the matching pulse SHALL change 2+DB_CYCLES clk cycles after the first clk edge that samples the new raw value.
REQ-021 Channels SHALL be fully independent; simultaneous presses on several keys SHALL produce pulses in the same cycle on each affected bit.
REQ-022 key_press and key_release of one channel SHALL never be high in the same cycle.

Reset
REQ-023 While reset_n=0: synchronizer flops SHALL hold 1 (released); all FSMs SHALL be in RELEASED; counters SHALL be 0; key_level, key_press and key_release SHALL be 0.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL abandon the operation with no pulse emitted.
REQ-025 A key held across reset release SHALL be reported as a fresh press per REQ-020.

Configuration
REQ-026 With macro KEY_REPEAT_EN defined: in HELD, a second per-channel counter SHALL emit an extra key_press pulse after REPEAT_DELAY_MS of continuous HELD, then every REPEAT_RATE_MS. The counter SHALL clear whenever the channel leaves HELD; RELEASE_WAIT SHALL pause repeats.
REQ-027 Without KEY_REPEAT_EN: no repeat counters SHALL be synthesized, and exactly one key_press SHALL occur per accepted press regardless of hold time.

Verification (CLK_FREQ_HZ=1000, DEBOUNCE_MS=4 -> DB_CYCLES=4)
REQ-028 Clean press: key_n[3] 1->0 held 20 cycles -> key_press[3] is a single pulse 6 cycles later, and key_level[3]=1 from that cycle.
REQ-029 Bounce: key_n[0] low for 2 cycles, high for 1, then low steady -> no pulse during the glitch; one key_press[0] 6 cycles after the final fall.
REQ-030 Release: a held key goes high with a 1-cycle low glitch at cycle 2 -> one key_release exactly 6 cycles after the glitch ends; key_level stays 1 until then.
REQ-031 Simultaneous: key_n 4'b1111->4'b0000 -> all four key_press bits pulse in the same cycle.
REQ-032 Reset mid-PRESS_WAIT: assert reset_n=0 three cycles after the press -> all outputs 0 immediately; after release of reset with the key still low, a press is reported 6 cycles later.
REQ-033 With KEY_REPEAT_EN, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=5, key held 30 cycles -> key_press at cycles 6, 16, 21, 26, 31 relative to the press.

Source files
------------

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Conditions NUM_KEYS raw, active-low, asynchronous pushbutton pins into clean
// debounced levels plus one-cycle press/release strobes.
//
// Each channel:
//   raw key_n -> two-flop synchronizer -> invert -> s (active-high sample)
//   s -> four-state debounce FSM (RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT)
//   A level change is accepted only after s has been stable for DB_CYCLES
//   consecutive FSM evaluations. A clean edge appears on the outputs
//   2 + DB_CYCLES clocks after the first clk edge that samples it.
//
// Optional feature (compile-time macro KEY_REPEAT_EN):
//   While a key stays HELD, extra key_press pulses are emitted after
//   REPEAT_DELAY_MS and then every REPEAT_RATE_MS. Without the macro no repeat
//   counters exist and each accepted press yields exactly one key_press.
//
// Parameters:
//   CLK_FREQ_HZ      system clock frequency in Hz
//   NUM_KEYS         number of independent pushbutton channels
//   DEBOUNCE_MS      stable time before a level change is accepted
//   REPEAT_DELAY_MS  hold time before first auto-repeat (KEY_REPEAT_EN only)
//   REPEAT_RATE_MS   auto-repeat period (KEY_REPEAT_EN only)
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   key_n        in   [NUM_KEYS] raw board keys, active-low, asynchronous
//   key_level    out  [NUM_KEYS] debounced level, 1 = held
//   key_press    out  [NUM_KEYS] one-cycle pulse per accepted press / repeat
//   key_release  out  [NUM_KEYS] one-cycle pulse per accepted release
// -----------------------------------------------------------------------------
module key_conditioner #(
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  // ---------------------------------------------------------------------------
  // Cycle constants. Each is clamped to at least 1 so that very slow clocks or
  // zero-millisecond settings still give a legal terminal count.
  // ---------------------------------------------------------------------------
  localparam int CYC_PER_MS   = CLK_FREQ_HZ / 1000;
  localparam int DB_RAW       = CYC_PER_MS * DEBOUNCE_MS;
  localparam int DB_CYCLES    = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int RPT_DLY_RAW  = CYC_PER_MS * REPEAT_DELAY_MS;
  localparam int RPT_DLY_CYC  = (RPT_DLY_RAW < 1) ? 1 : RPT_DLY_RAW;
  localparam int RPT_RATE_RAW = CYC_PER_MS * REPEAT_RATE_MS;
  localparam int RPT_RATE_CYC = (RPT_RATE_RAW < 1) ? 1 : RPT_RATE_RAW;

  // Counter width covers the largest cycle constant with one spare bit, so a
  // counter can never wrap before reaching its terminal value.
  localparam int MAX_A      = (DB_CYCLES > RPT_DLY_CYC) ? DB_CYCLES : RPT_DLY_CYC;
  localparam int MAX_CYCLES = (MAX_A > RPT_RATE_CYC) ? MAX_A : RPT_RATE_CYC;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DLY_LAST  = CNT_W'(RPT_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_RATE_LAST = CNT_W'(RPT_RATE_CYC - 1);
`endif

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. Resets to 1 (keys released) so that a key held
  // through reset is seen as a fresh falling edge once reset is removed.
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] sync_q1;
  logic [NUM_KEYS-1:0] sync_q2;
  logic [NUM_KEYS-1:0] s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      // NOTE: non-blocking assignments keep both flops sampling the values
      // from before this edge; a blocking chain would collapse them into one.
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
    end
  end

  assign s = ~sync_q2;

  // ---------------------------------------------------------------------------
  // Per-channel debounce FSM with registered outputs.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] db_cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
`ifdef KEY_REPEAT_EN
    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_armed;  // 0: waiting initial delay, 1: repeating
`endif

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state     <= RELEASED;
        db_cnt    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef KEY_REPEAT_EN
        rpt_cnt   <= '0;
        rpt_armed <= 1'b0;
`endif
      end else begin
        // Strobes are high only in the cycle a transition sets them.
        press_q   <= 1'b0;
        release_q <= 1'b0;

        case (state)
          RELEASED: begin
            if (s[i]) begin
              state  <= PRESS_WAIT;
              db_cnt <= '0;
            end
          end

          PRESS_WAIT: begin
            if (!s[i]) begin
              state <= RELEASED;  // bounce rejected, no pulse
            end else if (db_cnt == DB_LAST) begin
              state   <= HELD;
              level_q <= 1'b1;
              press_q <= 1'b1;
`ifdef KEY_REPEAT_EN
              rpt_cnt   <= '0;
              rpt_armed <= 1'b0;
`endif
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end

          HELD: begin
            if (!s[i]) begin
              state  <= RELEASE_WAIT;
              db_cnt <= '0;
`ifdef KEY_REPEAT_EN
              // Leaving HELD restarts the repeat schedule from scratch, so a
              // release glitch pauses repeats rather than advancing them.
              rpt_cnt   <= '0;
              rpt_armed <= 1'b0;
`endif
            end
`ifdef KEY_REPEAT_EN
            else if (rpt_cnt == (rpt_armed ? RPT_RATE_LAST : RPT_DLY_LAST)) begin
              press_q   <= 1'b1;
              rpt_cnt   <= '0;
              rpt_armed <= 1'b1;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
`endif
          end

          RELEASE_WAIT: begin
            if (s[i]) begin
              state <= HELD;  // release bounce rejected, level stays 1
            end else if (db_cnt == DB_LAST) begin
              state     <= RELEASED;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end

          // NOTE: the default arm recovers from any illegal encoding and
          // keeps the case complete, so no state bit can be left unassigned.
          default: begin
            state  <= RELEASED;
            db_cnt <= '0;
          end
        endcase
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end : g_ch

endmodule : key_conditioner

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//
// Scoreboard bench for key_conditioner at CLK_FREQ_HZ=1000, DEBOUNCE_MS=4
// (DB_CYCLES=4). Each stimulus step pushes the pulses it should cause, tagged
// with the absolute cycle count they must appear in; a monitor pops and
// compares on every cycle carrying a press or release pulse.
//
// Timing convention: inputs change on the falling edge while cyc = c, so the
// first sampling rising edge makes cyc = c+1 and the output edge lands
// 2 + DB_CYCLES = 6 edges later, observed at cyc = c+7.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

  localparam int NK  = 4;
  localparam int LAT = 7;  // drive-to-observe distance in cycles (1 + 2 + 4)

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  key_conditioner #(
    .CLK_FREQ_HZ    (1000),
    .NUM_KEYS       (NK),
    .DEBOUNCE_MS    (4),
    .REPEAT_DELAY_MS(10),
    .REPEAT_RATE_MS (5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            at;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
  } want_t;

  want_t want_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push(input int at, input logic [NK-1:0] press, input logic [NK-1:0] rel);
    want_t w;
    w.at    = at;
    w.press = press;
    w.rel   = rel;
    want_q.push_back(w);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && ((key_press | key_release) != '0)) begin
      if (want_q.size() == 0) begin
        check("unexpected_pulse", {24'd0, key_press, key_release}, 32'd0);
      end else begin
        want_t w;
        w = want_q.pop_front();
        check("pulse_cycle", cyc, w.at);
        check("press_mask", {28'd0, key_press}, {28'd0, w.press});
        check("release_mask", {28'd0, key_release}, {28'd0, w.rel});
      end
    end
  end

  initial begin
    int c;
    reset_n = 1'b0;
    key_n   = '1;

    // Reset state
    step(3);
    check("reset_level", {28'd0, key_level}, 32'd0);
    check("reset_press", {28'd0, key_press}, 32'd0);
    check("reset_release", {28'd0, key_release}, 32'd0);
    reset_n = 1'b1;
    step(3);

    // Clean press on key 3, held 20 cycles, then clean release
    c = cyc;
    key_n[3] = 1'b0;
    push(c + LAT, 4'b1000, 4'b0000);
    step(LAT - 1);
    check("clean_level_before", {28'd0, key_level}, 32'h0);
    step(1);
    check("clean_level_after", {28'd0, key_level}, 32'h8);
    step(13);
    c = cyc;
    key_n[3] = 1'b1;
    push(c + LAT, 4'b0000, 4'b1000);
    step(10);
    check("clean_level_released", {28'd0, key_level}, 32'h0);

    // Bounce on key 0: low 2, high 1, then low steady
    key_n[0] = 1'b0;
    step(2);
    key_n[0] = 1'b1;
    step(1);
    c = cyc;
    key_n[0] = 1'b0;
    push(c + LAT, 4'b0001, 4'b0000);
    step(LAT - 1);
    check("bounce_level_before", {28'd0, key_level}, 32'h0);
    step(6);
    check("bounce_level_held", {28'd0, key_level}, 32'h1);

    // Release of key 0 with a one-cycle low glitch at cycle 2
    key_n[0] = 1'b1;
    step(2);
    key_n[0] = 1'b0;
    step(1);
    c = cyc;
    key_n[0] = 1'b1;
    push(c + LAT, 4'b0000, 4'b0001);
    step(LAT - 1);
    check("glitch_level_still_held", {28'd0, key_level}, 32'h1);
    step(1);
    check("glitch_level_released", {28'd0, key_level}, 32'h0);
    step(5);

    // Simultaneous press and release on all keys
    c = cyc;
    key_n = 4'b0000;
    push(c + LAT, 4'b1111, 4'b0000);
    step(LAT);
    check("simul_level", {28'd0, key_level}, 32'hF);
    step(5);
    c = cyc;
    key_n = 4'b1111;
    push(c + LAT, 4'b0000, 4'b1111);
    step(10);
    check("simul_level_released", {28'd0, key_level}, 32'h0);

    // Reset during PRESS_WAIT on key 2, key still low after reset release
    key_n[2] = 1'b0;
    step(3);
    reset_n = 1'b0;
    #1;
    check("midreset_level", {28'd0, key_level}, 32'h0);
    check("midreset_press", {28'd0, key_press}, 32'h0);
    check("midreset_release", {28'd0, key_release}, 32'h0);
    step(3);
    c = cyc;
    reset_n = 1'b1;
    push(c + LAT, 4'b0100, 4'b0000);
    step(LAT - 1);
    check("postreset_level_before", {28'd0, key_level}, 32'h0);
    step(1);
    check("postreset_level_after", {28'd0, key_level}, 32'h4);
    step(3);
    c = cyc;
    key_n[2] = 1'b1;
    push(c + LAT, 4'b0000, 4'b0100);
    step(10);

    // Long hold on key 1 (30 cycles): repeats only when the feature is built in
    c = cyc;
    key_n[1] = 1'b0;
    push(c + LAT, 4'b0010, 4'b0000);
`ifdef KEY_REPEAT_EN
    push(c + LAT + 10, 4'b0010, 4'b0000);
    push(c + LAT + 15, 4'b0010, 4'b0000);
    push(c + LAT + 20, 4'b0010, 4'b0000);
    push(c + LAT + 25, 4'b0010, 4'b0000);
`endif
    step(30);
    check("hold_level", {28'd0, key_level}, 32'h2);
    c = cyc;
    key_n[1] = 1'b1;
    push(c + LAT, 4'b0000, 4'b0010);
    step(12);
    check("hold_level_released", {28'd0, key_level}, 32'h0);

    check("scoreboard_drained", want_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_key_conditioner
